lsearch_ctrl: RTL

Sequencing controller for the linear-search datapath. It owns the address and write-enable of the small synchronous search RAM and shares that RAM between a host loader and the search engine. The search engine latches a key, scans the RAM from address 0 upward, and reports the first matching index or a miss. It sits between the host/start logic and the RAM plus key-register datapath.

---
 rtl/lsearch_ctrl.sv | 107 ++++++++++
 1 files changed

// File: rtl/lsearch_ctrl.sv
// Purpose: shares the search RAM between host writes and a linear key search; reports first hit index or a miss.
// Latency: hit at index i gives done i+2 cycles after start; a miss gives done DEPTH+1 cycles after start.
// Backpressure: none; start while busy is ignored, host writes while busy or out of range are dropped with a wr_drop pulse.
module lsearch_ctrl #(
    parameter int DEPTH = 5,
    parameter int AW    = 3,
    parameter int DW    = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [DW-1:0] key,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [DW-1:0] ram_wdata,
    output logic          ram_re,
    input  logic [DW-1:0] ram_rdata,
    output logic          busy,
    output logic          done,
    output logic          found,
    output logic [AW-1:0] match_addr,
    output logic          wr_drop
);

    // Extra bit on the issue counter keeps it from wrapping when DEPTH == 2^AW.
    localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_C  = AW'(DEPTH - 1);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t        state;
    logic [AW:0]   issue_cnt;
    logic          cmp_valid;
    logic [AW-1:0] cmp_addr;
    logic [DW-1:0] key_q;
    logic          addr_ok;

    assign addr_ok   = ({1'b0, host_addr} < DEPTH_C);
    assign busy      = (state == SCAN);
    assign ram_wdata = host_wdata;

    // RAM port mux: host passthrough while idle, scan address stream while searching.
    always_comb begin
        ram_addr = host_addr;
        ram_we   = host_we && addr_ok && !reset;
        ram_re   = 1'b0;
        if (state == SCAN) begin
            ram_addr = issue_cnt[AW-1:0];
            ram_we   = 1'b0;
            ram_re   = (issue_cnt < DEPTH_C);
        end
    end

    // Search FSM: issue stage walks addresses, compare stage checks data returned one cycle later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            issue_cnt  <= '0;
            cmp_valid  <= 1'b0;
            cmp_addr   <= '0;
            key_q      <= '0;
            done       <= 1'b0;
            found      <= 1'b0;
            match_addr <= '0;
            wr_drop    <= 1'b0;
        end else begin
            done    <= 1'b0;
            wr_drop <= host_we && ((state == SCAN) || !addr_ok);
            case (state)
                IDLE: begin
                    if (start) begin
                        key_q      <= key;
                        issue_cnt  <= '0;
                        cmp_valid  <= 1'b0;
                        found      <= 1'b0;
                        match_addr <= '0;
                        state      <= SCAN;
                    end
                end
                SCAN: begin
                    if (issue_cnt < DEPTH_C) begin
                        issue_cnt <= issue_cnt + 1'b1;
                    end
                    cmp_valid <= ram_re;
                    cmp_addr  <= ram_addr;
                    if (cmp_valid) begin
                        if (ram_rdata == key_q) begin
                            found      <= 1'b1;
                            match_addr <= cmp_addr;
                            done       <= 1'b1;
                            state      <= IDLE;
                        end else if (cmp_addr == LAST_C) begin
                            found <= 1'b0;
                            done  <= 1'b1;
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
